// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the pattern detector input x.
// One word shifts out of sreg while a second may wait in hold, so back-to-back words leave no gap.
module seq_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] sreg, hold;
    logic [CW-1:0]    cnt, bit_idx;
    logic             hold_full;
    logic             accept, last;
    logic             load_din, load_hold, write_hold;

    assign din_ready = !hold_full;
    assign accept    = din_valid && din_ready;
    assign last      = (state == SHIFT) && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // On the last bit a held word takes priority over a fresh accept.
    // din_ready is low whenever hold is full, so the two never coincide.
    always_comb begin
        state_next = state;
        load_din   = 1'b0;
        load_hold  = 1'b0;
        write_hold = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_din   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST)   write_hold = accept;
                else if (hold_full) load_hold = 1'b1;
                else if (accept)    load_din  = 1'b1;
                else                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            hold      <= '0;
            cnt       <= '0;
            hold_full <= 1'b0;
        end else begin
            if (load_din) begin
                sreg <= din;
                cnt  <= '0;
            end else if (load_hold) begin
                sreg <= hold;
                cnt  <= '0;
            end else if (last) begin
                cnt  <= '0;
            end else if (state == SHIFT) begin
                cnt  <= cnt + 1'b1;
            end

            if (write_hold)     hold <= din;
            if (write_hold)     hold_full <= 1'b1;
            else if (load_hold) hold_full <= 1'b0;
        end
    end

    assign bit_idx   = MSB_FIRST ? (LAST - cnt) : cnt;
    assign x_valid   = (state == SHIFT);
    assign x         = x_valid ? sreg[bit_idx] : IDLE_BIT;
    assign word_done = last;
    assign busy      = x_valid || hold_full;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: expected bits are queued on accept and
// compared at every falling edge; one MSB-first and one LSB-first instance.
module tb_seq_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_valid_l = 1'b0;

    logic din_ready, x, x_valid, word_done, busy;
    logic din_ready_l, x_l, x_valid_l, word_done_l, busy_l;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_accept = 0;
    int pos = 0;
    int pos_l = 0;
    bit det = 1'b0;
    logic [3:0] hist = '0;
    bit q[$];
    bit ql[$];

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid),
        .word_done(word_done), .busy(busy)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid_l),
        .din_ready(din_ready_l), .x(x_l), .x_valid(x_valid_l),
        .word_done(word_done_l), .busy(busy_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MSB-first monitor: a pending expected bit must appear on x with x_valid, no gaps.
    always @(negedge clk) begin
        if (!reset) begin
            pos = 0;
        end else begin
            check("valid_vs_queue", x_valid, q.size() != 0);
            if (x_valid && q.size() != 0) begin
                check("word_done", word_done, pos == W - 1);
                hist = {hist[2:0], x};
                if (hist == 4'b0110) det = 1'b1;
                check("x_bit", x, q.pop_front());
                pos = (pos + 1) % W;
            end else begin
                check("idle_level", x, 1);
                check("no_done", word_done, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            pos_l = 0;
        end else begin
            check("lsb_valid_vs_queue", x_valid_l, ql.size() != 0);
            if (x_valid_l && ql.size() != 0) begin
                check("lsb_word_done", word_done_l, pos_l == W - 1);
                check("lsb_x_bit", x_l, ql.pop_front());
                pos_l = (pos_l + 1) % W;
            end else begin
                check("lsb_idle_level", x_l, 1);
                check("lsb_no_done", word_done_l, 0);
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        din = w;
        din_valid = 1'b1;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready) check("accept_timeout", din_ready, 1);
        @(posedge clk);
        last_accept = cyc;
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
    endtask

    task automatic send_l(input logic [W-1:0] w);
        int n = 0;
        @(negedge clk);
        din = w;
        din_valid_l = 1'b1;
        while (!din_ready_l && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!din_ready_l) check("lsb_accept_timeout", din_ready_l, 1);
        @(posedge clk);
        for (int i = 0; i < int'(W); i++) ql.push_back(w[i]);
    endtask

    task automatic idle();
        @(negedge clk);
        din_valid = 1'b0;
        din_valid_l = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || ql.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", q.size() + ql.size(), 0);
    endtask

    initial begin
        int ta;
        #1;
        check("rst_x", x, 1);
        check("rst_x_valid", x_valid, 0);
        check("rst_word_done", word_done, 0);
        check("rst_busy", busy, 0);
        check("rst_din_ready", din_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // single word, detector pattern 0110 embedded
        send(8'b0110_0000);
        idle();
        drain();
        check("detector_fired", det, 1);
        check("after_word_x_valid", x_valid, 0);

        // back-to-back words with din_valid held high
        send(8'hA5);
        send(8'h3C);
        idle();
        drain();

        // backpressure: third word must wait for hold to drain
        send(8'hC3);
        ta = last_accept;
        send(8'h81);
        @(negedge clk);
        check("bp_din_ready_low", din_ready, 0);
        check("bp_busy", busy, 1);
        send(8'h7E);
        check("bp_c_accept_edge", last_accept - ta, 9);
        idle();
        drain();

        // LSB-first instance
        send_l(8'h06);
        idle();
        drain();

        // reset mid-word with hold full
        send(8'hF0);
        send(8'h0F);
        idle();
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #1;
        reset = 1'b0;
        q.delete();
        ql.delete();
        #1;
        check("midrst_x", x, 1);
        check("midrst_x_valid", x_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_din_ready", din_ready, 1);
        check("midrst_word_done", word_done, 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("postrst_x", x, 1);
        check("postrst_x_valid", x_valid, 0);
        check("postrst_busy", busy, 0);

        // idle stream
        repeat (20) @(negedge clk);
        #1;
        check("idle_x_valid", x_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial stage that feeds the serial pattern detector input `x`. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts words out one bit per clock with no gaps between back-to-back words. When no word is in flight it drives a constant idle level, so the downstream detector sees a continuous, well-defined bit stream.

## Interface
- `WIDTH`, 8, bits per word; legal range 2..32.
- `MSB_FIRST`, 1, 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
- `IDLE_BIT`, 1, level driven on `x` when no word is being shifted.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `din`  in  WIDTH  parallel word to serialize.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  block can accept `din` this cycle.
- `x`  out  1  serial bit to the detector; registered.
- `x_valid`  out  1  `x` carries a data bit; registered.
- `word_done`  out  1  high during the cycle that carries the last bit of a word; registered.
- `busy`  out  1  high when `x_valid` is high or the holding register is full.

## Operation
- Internal state:
  - shift register `sreg` [WIDTH].
  - bit counter `cnt` [clog2(WIDTH)].
  - holding register `hold` [WIDTH] with flag `hold_full`.
  - FSM with states IDLE and SHIFT.
- `din_ready` is combinational and equals `!hold_full`.
- A word is accepted at a rising edge when `din_valid && din_ready`.
- IDLE:
  - `x = IDLE_BIT`, `x_valid = 0`.
  - On accept, `din` loads directly into `sreg`, `cnt = 0`, and the FSM goes to SHIFT. The word bypasses `hold`.
- SHIFT:
  - `x_valid = 1`.
  - `x` is the `sreg` bit selected by `cnt` and MSB_FIRST.
  - `cnt` increments each edge.
- SHIFT, non-last bit (`cnt != WIDTH-1`): an accept writes `hold` and sets `hold_full`.
- SHIFT, last bit (`cnt == WIDTH-1`), evaluated in priority order:
  - `hold_full`: `hold` loads into `sreg`, `cnt = 0`, FSM stays in SHIFT, `hold_full` clears.
  - Otherwise, if an accept occurs on this edge: `din` loads into `sreg`, `cnt = 0`, FSM stays in SHIFT.
  - Otherwise: FSM goes to IDLE.
- `word_done` is high exactly when `x_valid && cnt == WIDTH-1`.
- The block never drops or reorders words. At most two words are resident: one in `sreg`, one in `hold`.

## Timing
- Reset values while `reset` is low, taking effect immediately:
  - `x = IDLE_BIT`, `x_valid = 0`, `word_done = 0`, `busy = 0`, `din_ready = 1`.
  - `cnt = 0`, `hold_full = 0`, FSM in IDLE.
- Latency: a word accepted at edge N drives its first bit on `x` in the cycle after edge N (when the FSM was IDLE or at the last bit). Its last bit appears after edge N+WIDTH-1.
- Throughput: one bit per clock. Back-to-back words produce contiguous `x_valid` with no idle bit between them.
- Backpressure: `din_ready` falls in the cycle after a word enters `hold`. It rises in the cycle after the edge at which `hold` transfers into `sreg`.
- Reset asserted mid-word: the in-flight word and the held word are both discarded. No partial word resumes after reset releases.
- `din_valid` with `din_ready` low has no effect. The upstream source holds `din` until accepted.

## Test plan
- Single word, MSB_FIRST=1, `din = 8'b0110_0000` accepted at edge 0:
  - `x` = 0,1,1,0,0,0,0,0 after edges 0..7.
  - `x_valid` high 8 cycles; `word_done` high after edge 7.
  - `x = 1` and `x_valid = 0` after edge 8.
  - A downstream "0110" detector fires on this stream.
- Back-to-back, `din_valid` held high with words 8'hA5 then 8'h3C:
  - 16 contiguous `x_valid` cycles carrying 1010_0101_0011_1100.
  - `word_done` after edges 7 and 15.
- Backpressure, three words offered continuously:
  - A accepted at edge 0; B accepted at edge 1 into `hold`.
  - `din_ready` low after edges 1..7; C accepted at edge 9.
  - No bit gaps in the output; output order is A, B, C.
- LSB-first, MSB_FIRST=0, `din = 8'h06`: `x` = 0,1,1,0,0,0,0,0.
- Reset mid-word: assert `reset` low after the 3rd bit, with `hold` full.
  - Immediately: `x = IDLE_BIT`, `x_valid = 0`, `busy = 0`, `din_ready = 1`.
  - After release with no input, `x` stays at `IDLE_BIT`.
- Idle stream: no `din_valid` for 20 cycles. `x` is constant `IDLE_BIT`, `x_valid = 0`, and `word_done` never asserts.
